mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Pipeline-side initiator for the byte-organised data memory of the datapath. Accepts one load or store per request from the MEM stage and performs it as a sequence of single-byte memory cycles (1, 2 or 4 beats), big-endian. Drives the memory's address/memread/memwrite/writedata strobes and collects read bytes. Holds `busy` for the pipeline stall logic until the access completes.

## Interface
- `MEM_BYTES`, 40: data memory depth in bytes; valid addresses 0..MEM_BYTES-1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request strobe; sampled only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low `8*size` bits used.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = misaligned, out-of-range or illegal size.
- `rdata`  out  32  load result; updated only on a successful load's `done`.
- `mem_address`  out  32  byte address to memory.
- `mem_memread`  out  1  read strobe.
- `mem_memwrite`  out  1  write strobe.
- `mem_writedata`  out  8  byte to write.
- `mem_read_data`  in  8  byte from memory, combinational from `mem_address`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: when `req_valid`=1, latch write/size/signed/addr/wdata and check:
  - size 11 -> error;
  - halfword with addr[0]=1, or word with addr[1:0]!=0 -> error;
  - addr + nbytes - 1 >= MEM_BYTES -> error (32-bit compare, no wrap).
- Error: go to RESP with err flag; no memory strobe is ever asserted.
- Otherwise go to ACCESS with beat counter = 0 and nbytes = 1/2/4.
- ACCESS, beat k (k = 0..nbytes-1):
  - `mem_address` = addr + k;
  - store: `mem_memwrite`=1, `mem_memread`=0, `mem_writedata` = byte k of the stored value, MSB first. For word data that is wdata[31-8k -: 8]; for halfword data, wdata[15-8k -: 8]; for byte data, wdata[7:0].
  - load: `mem_memread`=1, `mem_memwrite`=0; shift register captures `mem_read_data` at the end of the beat (shift left 8, insert LSB).
- After the last beat, go to RESP.
- RESP (one cycle): `done`=1, `err` = error flag. On a successful load, `rdata` is registered as the extended value:
  - byte: sign bit 7 when signed;
  - halfword: sign bit 15 when signed;
  - word: no extension.
  Then go to IDLE.
- Strobes are never both high. Outside ACCESS: both strobes 0, `mem_address`=0, `mem_writedata`=0.
- `req_valid` while busy is ignored; the requester must hold the request until it sees IDLE (busy=0).

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, rdata 0, mem_address 0, mem_memread 0, mem_memwrite 0, mem_writedata 0.
- Outputs are registered or decoded from registered state only; there is no combinational path from req_* to any output.
- Request accepted at edge E0. Beats occupy cycles E0+1..E0+n. `done` is high in cycle E0+n+1, and IDLE is reached at E0+n+2.
- Latency from accept to done: byte 2 cycles, halfword 3, word 5, error 1 cycle.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP. Throughput for words is 1 per 6 cycles.
- `rdata` holds until the next successful load's RESP. Stores and errors leave it unchanged.
- Reset mid-access: everything returns to reset values immediately, with no `done`. Bytes already written by a partial store remain in memory.

## Test plan
- Word store then word load: store addr 4, wdata 0xDEADBEEF. Required beats are mem_address 4,5,6,7 with writedata DE,AD,BE,EF, memwrite=1 for exactly 4 cycles, and done at accept+5. Load addr 4 then returns rdata 0xDEADBEEF, err 0.
- Signed/unsigned byte: memory[9]=0x80. lb (signed) gives 0xFFFFFF80 and lbu gives 0x00000080, each with done at accept+2 and 1 memread beat.
- Halfword: store 0x1234ABCD at addr 10 as a halfword, which writes bytes AB,CD to 10,11. lh gives 0xFFFFABCD and lhu gives 0x0000ABCD.
- Errors: word at addr 6, halfword at addr 3, size 11, and word at addr 38 (with MEM_BYTES=40). Each gives done+err at accept+1, no strobes ever, and rdata unchanged.
- Busy/ignore: a second req_valid pulse during a word load is ignored (exactly one done). A request held through busy is accepted in the first IDLE cycle.
- Reset mid-store: rst_n low after beat 2 of a word store to addr 0. Outputs go to 0 asynchronously, no done; afterwards bytes 0–1 are updated and bytes 2–3 are unchanged. A fresh byte load then works normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Pipeline-side initiator for the byte-organised data memory. A load or store
// request from the MEM stage runs as 1, 2 or 4 single-byte memory cycles,
// most significant byte first. Illegal requests (size 11, misaligned, or
// extending past the end of memory) complete in one cycle with err set, and
// never touch the memory strobes. busy stalls the pipeline until the access
// completes.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid         request strobe, sampled only while idle
//   req_write         1 = store, 0 = load
//   req_size[1:0]     00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed        loads only: sign-extend the result
//   req_addr[31:0]    byte address
//   req_wdata[31:0]   store data; only the low 8*size bits are used
//   busy              high whenever an access is in flight
//   done              one-cycle completion pulse
//   err               valid with done: request was rejected
//   rdata[31:0]       load result, updated only by a successful load
//   mem_address[31:0] byte address to memory
//   mem_memread       read strobe
//   mem_memwrite      write strobe
//   mem_writedata[7:0] byte to write
//   mem_read_data[7:0] byte from memory, combinational from mem_address
module mem_access_unit #(
  parameter int MEM_BYTES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [7:0]  mem_writedata,
  input  logic [7:0]  mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [1:0]  last_beat;

  // Request attributes held for the duration of the access.
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sgn_q;

  // Shared shift register: stores shift bytes out of the top, loads shift
  // read bytes into the bottom.
  logic [31:0] shreg;

  logic [2:0]  req_nbytes;
  logic [32:0] req_end;
  logic        req_bad;
  logic [31:0] wdata_aligned;
  logic [31:0] load_word;

  // Sign/zero extension of the assembled load value.
  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [1:0]  sz,
                                         input logic        sg);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[7:0];
    h = w[15:0];
    case (sz)
      2'b00:   extend = sg ? 32'(b) : {24'h0, w[7:0]};
      2'b01:   extend = sg ? 32'(h) : {16'h0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Request decode; feeds registers only, never an output directly.
  always_comb begin
    case (req_size)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
    // 33-bit end address so an address near 2^32 cannot wrap into range.
    req_end = {1'b0, req_addr} + 33'(req_nbytes) - 33'd1;
    req_bad = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (req_end >= 33'(MEM_BYTES));
    // Left-justify store data so the first byte to send is always [31:24].
    case (req_size)
      2'b00:   wdata_aligned = {req_wdata[7:0], 24'h0};
      2'b01:   wdata_aligned = {req_wdata[15:0], 16'h0};
      default: wdata_aligned = req_wdata;
    endcase
  end

  assign load_word = {shreg[23:0], mem_read_data};
  assign busy      = (state != IDLE);

  // Control and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat          <= 2'd0;
      last_beat     <= 2'd0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= 32'h0;
      mem_address   <= 32'h0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_writedata <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid) begin
            if (req_bad) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              // First beat is presented in the cycle right after acceptance.
              state         <= ACCESS;
              beat          <= 2'd0;
              last_beat     <= 2'(req_nbytes - 3'd1);
              mem_address   <= req_addr;
              mem_memread   <= !req_write;
              mem_memwrite  <= req_write;
              mem_writedata <= req_write ? wdata_aligned[31:24] : 8'h0;
            end
          end
        end
        // ---- ACCESS: one byte per cycle ----
        ACCESS: begin
          if (beat == last_beat) begin
            state         <= RESP;
            done          <= 1'b1;
            err           <= 1'b0;
            mem_address   <= 32'h0;
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            mem_writedata <= 8'h0;
            if (!wr_q)
              rdata <= extend(load_word, size_q, sgn_q);
          end else begin
            beat        <= beat + 2'd1;
            mem_address <= mem_address + 32'd1;
            if (wr_q)
              mem_writedata <= shreg[31:24];
          end
        end
        // ---- RESP: done/err pulse, then back to idle ----
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  // Data path registers; no reset needed, they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      wr_q   <= req_write;
      size_q <= req_size;
      sgn_q  <= req_signed;
      shreg  <= {wdata_aligned[23:0], 8'h0};
    end else if (state == ACCESS) begin
      shreg  <= load_word;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [7:0]  mem_writedata;
  logic [7:0]  mem_read_data;

  logic [7:0]  mem [0:63];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int both_cnt = 0;

  logic [7:0]  wexp [4]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [1:0]  esz [5]   = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
  logic [31:0] eaddr [5] = '{32'd6, 32'd3, 32'd0, 32'd38, 32'd40};

  mem_access_unit #(.MEM_BYTES(40)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .mem_address   (mem_address),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_writedata (mem_writedata),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: combinational read, write on the clock edge.
  assign mem_read_data = (mem_address < 32'd40) ? mem[mem_address[5:0]] : 8'h00;
  always @(posedge clk) begin
    if (mem_memwrite === 1'b1)
      mem[mem_address[5:0]] <= mem_writedata;
  end

  // Strobe / done activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_memwrite === 1'b1) wr_cnt <= wr_cnt + 1;
    if (mem_memread === 1'b1)  rd_cnt <= rd_cnt + 1;
    if (done === 1'b1)         done_cnt <= done_cnt + 1;
    if (mem_memread === 1'b1 && mem_memwrite === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
  endtask

  // Issue one request, wait (bounded) for done, check latency/err/beat counts,
  // then step into the following idle cycle.
  task automatic run(input string tag, input logic w, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input logic exp_err);
    int c;
    int wr0;
    int rd0;
    int beats;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    set_req(w, sz, sg, a, d);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    chk({tag, " latency"}, 32'(c), 32'(exp_lat));
    chk({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
    beats = exp_err ? 0 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
    chk({tag, " write beats"}, 32'(wr_cnt - wr0), w ? 32'(beats) : 32'd0);
    chk({tag, " read beats"}, 32'(rd_cnt - rd0), w ? 32'd0 : 32'(beats));
    step();
    chk({tag, " idle busy"}, {31'h0, busy}, 32'd0);
    chk({tag, " idle address"}, mem_address, 32'd0);
  endtask

  initial begin
    int c;
    int d0;
    int w0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    set_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // ---- reset values ----
    chk("rst busy", {31'h0, busy}, 32'd0);
    chk("rst done", {31'h0, done}, 32'd0);
    chk("rst err", {31'h0, err}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst address", mem_address, 32'd0);
    chk("rst memread", {31'h0, mem_memread}, 32'd0);
    chk("rst memwrite", {31'h0, mem_memwrite}, 32'd0);
    chk("rst writedata", {24'h0, mem_writedata}, 32'd0);
    rst_n = 1'b1;
    step();

    // Known contents for bytes 0..3, used by the reset-mid-store test.
    run("sw0", 1'b1, 2'd2, 1'b0, 32'd0, 32'h11223344, 5, 1'b0);

    // ---- word store with per-beat checks ----
    w0 = wr_cnt;
    set_req(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("sw beat address", mem_address, 32'(4 + k));
      chk("sw beat data", {24'h0, mem_writedata}, {24'h0, wexp[k]});
      chk("sw beat memwrite", {31'h0, mem_memwrite}, 32'd1);
      chk("sw beat memread", {31'h0, mem_memread}, 32'd0);
      step();
    end
    chk("sw done", {31'h0, done}, 32'd1);
    chk("sw err", {31'h0, err}, 32'd0);
    chk("sw memwrite off", {31'h0, mem_memwrite}, 32'd0);
    chk("sw write beats", 32'(wr_cnt - w0), 32'd4);
    step();
    chk("sw idle", {31'h0, busy}, 32'd0);

    run("lw", 1'b0, 2'd2, 1'b0, 32'd4, 32'h0, 5, 1'b0);
    chk("lw rdata", rdata, 32'hDEADBEEF);

    // ---- byte store / signed and unsigned byte loads ----
    run("sb", 1'b1, 2'd0, 1'b0, 32'd9, 32'h12345680, 2, 1'b0);
    chk("sb rdata kept", rdata, 32'hDEADBEEF);
    chk("sb memory", {24'h0, mem[9]}, 32'h80);
    run("lb", 1'b0, 2'd0, 1'b1, 32'd9, 32'h0, 2, 1'b0);
    chk("lb rdata", rdata, 32'hFFFFFF80);
    run("lbu", 1'b0, 2'd0, 1'b0, 32'd9, 32'h0, 2, 1'b0);
    chk("lbu rdata", rdata, 32'h00000080);

    // ---- halfword ----
    run("sh", 1'b1, 2'd1, 1'b0, 32'd10, 32'h1234ABCD, 3, 1'b0);
    chk("sh mem10", {24'h0, mem[10]}, 32'hAB);
    chk("sh mem11", {24'h0, mem[11]}, 32'hCD);
    run("lh", 1'b0, 2'd1, 1'b1, 32'd10, 32'h0, 3, 1'b0);
    chk("lh rdata", rdata, 32'hFFFFABCD);
    run("lhu", 1'b0, 2'd1, 1'b0, 32'd10, 32'h0, 3, 1'b0);
    chk("lhu rdata", rdata, 32'h0000ABCD);

    // ---- accesses ending exactly at the last byte ----
    run("sw36", 1'b1, 2'd2, 1'b0, 32'd36, 32'hA1B2C3D4, 5, 1'b0);
    chk("sw36 mem36", {24'h0, mem[36]}, 32'hA1);
    chk("sw36 mem39", {24'h0, mem[39]}, 32'hD4);
    run("lhu38", 1'b0, 2'd1, 1'b0, 32'd38, 32'h0, 3, 1'b0);
    chk("lhu38 rdata", rdata, 32'h0000C3D4);

    // ---- error requests: loads, so rdata would change if wrongly accepted ----
    for (int e = 0; e < 5; e++) begin
      run("error", 1'b0, esz[e], 1'b1, eaddr[e], 32'h0, 1, 1'b1);
      chk("error rdata kept", rdata, 32'h0000C3D4);
    end
    run("error store", 1'b1, 2'd2, 1'b0, 32'd6, 32'hFFFFFFFF, 1, 1'b1);
    chk("error store mem6", {24'h0, mem[6]}, 32'hBE);

    // ---- req_valid pulse during a busy word load is ignored ----
    d0 = done_cnt;
    set_req(1'b0, 2'd2, 1'b0, 32'd4, 32'h0);
    req_valid = 1'b1;
    step();
    set_req(1'b0, 2'd0, 1'b1, 32'd9, 32'h0);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("ignore done count", 32'(done_cnt - d0), 32'd1);
    chk("ignore rdata", rdata, 32'hDEADBEEF);
    chk("ignore idle", {31'h0, busy}, 32'd0);

    // ---- request held through busy is taken in the first idle cycle ----
    run("lhu pre", 1'b0, 2'd1, 1'b0, 32'd10, 32'h0, 3, 1'b0);
    set_req(1'b0, 2'd2, 1'b0, 32'd4, 32'h0);
    req_valid = 1'b1;
    step();
    set_req(1'b0, 2'd0, 1'b1, 32'd9, 32'h0);
    c = 1;
    while (done !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    chk("held first latency", 32'(c), 32'd5);
    chk("held first rdata", rdata, 32'hDEADBEEF);
    step();
    chk("held idle gap", {31'h0, busy}, 32'd0);
    step();
    chk("held accepted", {31'h0, busy}, 32'd1);
    req_valid = 1'b0;
    step();
    chk("held second done", {31'h0, done}, 32'd1);
    chk("held second rdata", rdata, 32'hFFFFFF80);
    step();
    chk("held idle", {31'h0, busy}, 32'd0);

    // ---- reset in the middle of a word store ----
    d0 = done_cnt;
    set_req(1'b1, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("midrst beat2 address", mem_address, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'h0, busy}, 32'd0);
    chk("midrst memwrite", {31'h0, mem_memwrite}, 32'd0);
    chk("midrst address", mem_address, 32'd0);
    chk("midrst writedata", {24'h0, mem_writedata}, 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("midrst no done", 32'(done_cnt - d0), 32'd0);
    chk("midrst mem0", {24'h0, mem[0]}, 32'hCA);
    chk("midrst mem1", {24'h0, mem[1]}, 32'hFE);
    chk("midrst mem2", {24'h0, mem[2]}, 32'h33);
    chk("midrst mem3", {24'h0, mem[3]}, 32'h44);
    run("lbu after reset", 1'b0, 2'd0, 1'b0, 32'd1, 32'h0, 2, 1'b0);
    chk("lbu after reset rdata", rdata, 32'h000000FE);

    chk("strobes never both high", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
